// File: rtl/rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
// The grant FSM has two states; the widths are derived from the requester count and the hold limit.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ  = 16;
    localparam int DEF_MAX_HOLD = 8;

    // Index width; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hold counter width; it must be able to hold values up to MAX_HOLD.
    function automatic int cnt_width(input int h);
        return (h > 0) ? $clog2(h + 1) : 1;
    endfunction

endpackage

// File: rtl/lsb_finder.sv
// Combinational lowest-set-bit finder.
// The index output is 0 when the input vector is empty.
module lsb_finder
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Scan from the top down so that the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
        found = |vec;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant.
// A grant ends on done, on a withdrawn request, or on a hold timeout; one idle cycle follows every grant.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDX_W    = idx_width(NUM_REQ),
    parameter int CNT_W    = cnt_width(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]     ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]     hold_cnt_r, hold_cnt_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0]     gnt_idx_r, gnt_idx_nxt_s;
    logic                 gnt_valid_r, gnt_valid_nxt_s;

    logic [NUM_REQ-1:0]   mask_s;
    logic [IDX_W-1:0]     masked_idx_s, raw_idx_s, win_idx_s;
    logic                 masked_found_s, raw_found_s, release_s;

    // Keep only requesters at or above the pointer.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_s[i] = (i >= int'(ptr_r)) ? 1'b1 : 1'b0;
        end
    end

    lsb_finder #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_masked_finder (
        .vec   (req & mask_s),
        .idx   (masked_idx_s),
        .found (masked_found_s)
    );

    lsb_finder #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_raw_finder (
        .vec   (req),
        .idx   (raw_idx_s),
        .found (raw_found_s)
    );

    assign win_idx_s = masked_found_s ? masked_idx_s : raw_idx_s;
    assign release_s = done || !req[gnt_idx_r] || (hold_cnt_r == CNT_W'(MAX_HOLD - 1));

    // Next-state, pointer, counter and grant outputs.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        gnt_nxt_s       = gnt_r;
        gnt_idx_nxt_s   = gnt_idx_r;
        gnt_valid_nxt_s = gnt_valid_r;
        case (state_r)
            IDLE: begin
                if (raw_found_s) begin
                    state_nxt_s     = GRANT;
                    gnt_nxt_s       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    gnt_idx_nxt_s   = win_idx_s;
                    gnt_valid_nxt_s = 1'b1;
                    hold_cnt_nxt_s  = '0;
                end else begin
                    gnt_nxt_s       = '0;
                    gnt_idx_nxt_s   = '0;
                    gnt_valid_nxt_s = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_nxt_s     = IDLE;
                    gnt_nxt_s       = '0;
                    gnt_idx_nxt_s   = '0;
                    gnt_valid_nxt_s = 1'b0;
                    ptr_nxt_s       = (gnt_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_r + IDX_W'(1);
                end else begin
                    hold_cnt_nxt_s  = hold_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                gnt_nxt_s       = '0;
                gnt_idx_nxt_s   = '0;
                gnt_valid_nxt_s = 1'b0;
                ptr_nxt_s       = '0;
                hold_cnt_nxt_s  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            hold_cnt_r  <= '0;
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_idx_r   <= gnt_idx_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;

endmodule
